sipo_deser: RTL
===============

Name: sipo_deser

Overview:
- Parameterised serial-to-parallel deserializer; next generation of the team's plain SIPO shift register.
- Adds:
  - configurable word width and bit order
  - per-bit input qualifier
  - frame restart
  - registered output word with valid/ready handshake
  - sticky overrun detection
- Sits between a serial receive front-end (bit-sampled link, SPI-like slave) and a word-oriented consumer.

Parameters:
- WIDTH, 8, bits per output word; legal range 2..32.
- MSB_FIRST, 0, 0: first received bit lands in out_data[0]; 1: first received bit lands in out_data[WIDTH-1].
- CNT_W, $clog2(WIDTH), width of the bit counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  in is sampled on a rising edge only when in_valid=1.
- frame_start  input  1  qualified by in_valid; marks the current bit as bit 0 of a new word, discarding any partial word.
- out_ready  input  1  consumer accepts out_data this cycle when out_valid=1.
- overrun_clr  input  1  synchronous clear of the overrun flag.
- parallel_out  output  WIDTH  live contents of the shift register (partial word).
- bit_cnt  output  CNT_W  bits already collected in the current word, 0..WIDTH-1.
- out_data  output  WIDTH  completed word, held stable while out_valid=1.
- out_valid  output  1  out_data holds an unaccepted word.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (clr=1, async): parallel_out=0, bit_cnt=0, out_data=0, out_valid=0, overrun=0. Reset mid-word discards the partial word and any held word.
- Shift rule, on each edge with in_valid=1:
  - MSB_FIRST=0: shift right, in enters at bit WIDTH-1.
  - MSB_FIRST=1: shift left, in enters at bit 0.
- in_valid=0: shift register and bit_cnt hold.
- Counter:
  - Increments on each qualified bit.
  - On the qualified bit where bit_cnt==WIDTH-1 (the last bit), bit_cnt wraps to 0.
  - On that same edge, the assembled word (register contents including the new bit) is the completed word.
- frame_start=1 with in_valid=1:
  - Shift register is loaded with only the new bit, in its first-bit position; all other bits become 0.
  - bit_cnt becomes 1.
  - Partial bits are dropped silently; no overrun.
- frame_start with in_valid=0 is ignored.
- Word completion and output register (all on the completion edge):
  - out_valid=0 before the edge: out_data loads the word; out_valid goes 1 on the same edge (zero added latency after the last bit).
  - out_valid=1 and out_ready=1: old word is consumed; new word loads; out_valid stays 1.
  - out_valid=1 and out_ready=0: new word is dropped; out_data keeps the old word; overrun is set to 1.
- Handshake:
  - Transfer occurs on an edge with out_valid=1 and out_ready=1.
  - With no simultaneous completion, out_valid goes 0 after the transfer; out_data retains its last value.
  - out_data never changes while out_valid=1 and out_ready=0.
- Overrun:
  - Set only as above; stays set until overrun_clr=1 or clr.
  - If set and clear happen on the same edge, set wins (overrun stays 1).
- Shifting continues regardless of out_valid/out_ready; the block never back-pressures the serial side.

Test Plan:
- Reset: clr pulsed mid-word after 3 bits -> all outputs 0 immediately (before the next clk edge); the next 8 bits form a fresh word.
- LSB-first word, WIDTH=8, MSB_FIRST=0: bits 1,0,1,1,0,0,1,0 with in_valid=1, out_ready=1 -> out_valid=1 for one cycle after the 8th edge, out_data=0x4D, bit_cnt=0.
- MSB-first word, MSB_FIRST=1, same bit sequence -> out_data=0xB2. Then in_valid gaps of 1-3 cycles between bits -> same 0xB2, bit_cnt frozen during gaps.
- Frame restart:
  - 5 bits sent, then frame_start with bit 1, then 7 more bits 0,1,1,0,0,1,0 (LSB-first) -> out_data=0x4D.
  - Partial word is discarded and overrun stays 0.
- Back-to-back and overrun:
  - out_ready=0; send word 0x4D, then word 0x11 -> out_data stays 0x4D, overrun=1.
  - Raise out_ready -> transfer of 0x4D, out_valid=0.
  - Pulse overrun_clr -> overrun=0.
- Simultaneous accept and complete: out_valid=1 with 0x4D, out_ready=1 on the edge completing 0xA5 -> out_data=0xA5, out_valid stays 1, overrun=0.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer with configurable width and bit order, frame restart,
// a registered output word behind a valid/ready handshake, and a sticky overrun flag.
module sipo_deser #(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in,
    input  logic             in_valid,
    input  logic             frame_start,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] parallel_out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    // Output handshake: out_valid/out_data form a valid/ready source. A word transfers on
    // any rising edge where out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0,
    // out_data is frozen. The serial side is never stalled: a word completing while the
    // held word is still unaccepted is dropped and flagged in overrun.

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             word_done;

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (in_valid) begin
            if (frame_start) begin
                // New frame: only the fresh bit survives, placed where a first bit lands.
                shift_d = MSB_FIRST ? {{(WIDTH-1){1'b0}}, in} : {in, {(WIDTH-1){1'b0}}};
                cnt_d   = CNT_W'(1);
            end else begin
                shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], in} : {in, shift_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    cnt_d     = '0;
                    word_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q & ~overrun_clr;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // The completed word includes the bit arriving on this edge, hence shift_d.
        if (word_done) begin
            if (!valid_q || out_ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign parallel_out = shift_q;
    assign bit_cnt      = cnt_q;
    assign out_data     = data_q;
    assign out_valid    = valid_q;
    assign overrun      = ovr_q;

endmodule
